mem_lsu: RTL and testbench

Memory-access stage of the RV32 pipeline: consumes the registered ALU result and store data from the EX/MEM pipeline register, performs byte/half/word loads and stores against the data memory with a valid/ready wait-state handshake, and delivers load data or the pass-through ALU result to the MEM/WB register. It stalls upstream while a memory access is outstanding and flags misaligned or illegal accesses instead of issuing them.

---
 rtl/rv_mem_pkg.sv | 21 ++
 rtl/lsu_load_align.sv | 25 ++
 rtl/mem_lsu.sv | 186 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the RV32 memory-access stage.
package rv_mem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    localparam int unsigned BeWidth = 4;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a 32-bit memory read word.
module lsu_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by access type
    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        unique case (funct3_i)
            Funct3Lb:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            Funct3Lh:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            Funct3Lbu: data_o = {24'h000000, shifted[7:0]};
            Funct3Lhu: data_o = {16'h0000, shifted[15:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// RV32 memory-access stage: issues aligned loads/stores with a valid/ready
// handshake, stalls upstream while outstanding, and faults bad accesses.
module mem_lsu
    import rv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [4:0]            rd_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [BeWidth-1:0]    dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_rd_o,
    output logic                  err_o
);

    lsu_state_e state_q, state_d;

    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BeWidth-1:0]    be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_q, rd_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  err_q, err_d;

    logic                  mem_op, is_store, illegal, misaligned, fault;
    logic [BeWidth-1:0]    store_be;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [DATA_WIDTH-1:0] load_data;

    lsu_load_align u_load_align (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    // Classify the incoming op: legality, alignment and store lane steering
    always_comb begin
        mem_op   = mem_read_i | mem_write_i;
        is_store = mem_write_i & ~mem_read_i;
        illegal  = 1'b0;
        if (mem_read_i && mem_write_i) begin
            illegal = 1'b1;
        end else if (mem_read_i) begin
            illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        end else if (mem_write_i) begin
            illegal = funct3_i > Funct3Sw;
        end
        case (funct3_i[1:0])
            2'b01:   misaligned = ALUOut[0];
            2'b10:   misaligned = ALUOut[1:0] != 2'b00;
            default: misaligned = 1'b0;
        endcase
        fault = mem_op & (illegal | misaligned);
        case (funct3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << ALUOut[1:0];
                store_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                store_be    = ALUOut[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = wdata_i;
            end
        endcase
    end

    // Next-state, request capture and writeback result selection
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        err_d      = 1'b0;
        stall_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op_valid_i) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ALUOut;
                        wb_rd_d    = rd_i;
                    end else if (fault) begin
                        err_d     = 1'b1;
                        wb_data_d = ALUOut;
                        wb_rd_d   = 5'd0;
                    end else begin
                        stall_o  = 1'b1;
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = ALUOut[ADDR_WIDTH-1:0];
                        funct3_d = funct3_i;
                        rd_d     = rd_i;
                        be_d     = is_store ? store_be : 4'b1111;
                        wdata_d  = is_store ? store_wdata : '0;
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                stall_o = ~dmem_ready_i;
                if (dmem_ready_i) begin
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = we_q ? '0 : load_data;
                    wb_rd_d    = we_q ? 5'd0 : rd_q;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_data_o    = wb_data_q;
    assign wb_rd_o      = wb_rd_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUOut, wdata_i;
    logic [4:0]  rd_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid_i   (op_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .ALUOut       (ALUOut),
        .wdata_i      (wdata_i),
        .rd_i         (rd_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_valid_i   = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        funct3_i     = 3'b000;
        ALUOut       = 32'h0;
        wdata_i      = 32'h0;
        rd_i         = 5'd0;
        dmem_ready_i = 1'b0;
        dmem_rdata_i = 32'h0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdst);
        op_valid_i  = 1'b1;
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        ALUOut      = addr;
        wdata_i     = wd;
        rd_i        = rdst;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", dmem_req_o); end
        n_cmp++; if (dmem_we_o !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", dmem_we_o); end
        n_cmp++; if (dmem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", dmem_addr_o); end
        n_cmp++; if (dmem_be_o !== 4'h0) begin n_err++; $display("FAIL rst_be: got %b want 0000", dmem_be_o); end
        n_cmp++; if (dmem_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", dmem_wdata_o); end
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'h0) begin n_err++; $display("FAIL rst_wb_data: got %h want 0", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd0) begin n_err++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lw_stall_T: got %b want 1", stall_o); end
        tick();
        idle_inputs();
        n_cmp++; if (dmem_req_o !== 1'b1) begin n_err++; $display("FAIL lw_req: got %b want 1", dmem_req_o); end
        n_cmp++; if (dmem_addr_o !== 32'h100) begin n_err++; $display("FAIL lw_addr: got %h want 100", dmem_addr_o); end
        n_cmp++; if (dmem_be_o !== 4'b1111) begin n_err++; $display("FAIL lw_be: got %b want 1111", dmem_be_o); end
        n_cmp++; if (dmem_we_o !== 1'b0) begin n_err++; $display("FAIL lw_we: got %b want 0", dmem_we_o); end
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lw_stall_T1: got %b want 0", stall_o); end
        tick();
        dmem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL lw_wb_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_wb_data: got %h want deadbeef", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd5) begin n_err++; $display("FAIL lw_wb_rd: got %0d want 5", wb_rd_o); end
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL lw_req_drop: got %b want 0", dmem_req_o); end
        tick();
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL lw_wb_pulse: got %b want 0", wb_valid_o); end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, f3[i], adr[i], 32'h0, 5'd10 + 5'(i));
            tick();
            idle_inputs();
            n_cmp++; if (dmem_addr_o !== {adr[i][31:2], 2'b00}) begin n_err++; $display("FAIL ld%0d_addr: got %h want %h", i, dmem_addr_o, {adr[i][31:2], 2'b00}); end
            dmem_ready_i = 1'b1;
            dmem_rdata_i = 32'h80FF0000;
            tick();
            dmem_ready_i = 1'b0;
            n_cmp++; if (wb_data_o !== exp[i]) begin n_err++; $display("FAIL ld%0d_data: got %h want %h", i, wb_data_o, exp[i]); end
            n_cmp++; if (wb_rd_o !== 5'd10 + 5'(i)) begin n_err++; $display("FAIL ld%0d_rd: got %0d want %0d", i, wb_rd_o, 10 + i); end
        end
        // LHU at the upper half
        issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd3);
        tick();
        idle_inputs();
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h80FF0000;
        tick();
        dmem_ready_i = 1'b0;
        n_cmp++; if (wb_data_o !== 32'h000080FF) begin n_err++; $display("FAIL lhu_data: got %h want 000080ff", wb_data_o); end
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 5'd4);
        tick();
        idle_inputs();
        n_cmp++; if (dmem_addr_o !== 32'h200) begin n_err++; $display("FAIL sb_addr: got %h want 200", dmem_addr_o); end
        n_cmp++; if (dmem_be_o !== 4'b0010) begin n_err++; $display("FAIL sb_be: got %b want 0010", dmem_be_o); end
        n_cmp++; if (dmem_wdata_o !== 32'hABABABAB) begin n_err++; $display("FAIL sb_wdata: got %h want abababab", dmem_wdata_o); end
        n_cmp++; if (dmem_we_o !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b want 1", dmem_we_o); end
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL sb_wb_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'h0) begin n_err++; $display("FAIL sb_wb_data: got %h want 0", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd0) begin n_err++; $display("FAIL sb_wb_rd: got %0d want 0", wb_rd_o); end
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hFFFF1234, 5'd4);
        tick();
        idle_inputs();
        n_cmp++; if (dmem_be_o !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b want 1100", dmem_be_o); end
        n_cmp++; if (dmem_wdata_o !== 32'h12341234) begin n_err++; $display("FAIL sh_wdata: got %h want 12341234", dmem_wdata_o); end
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
    endtask

    task automatic test_fault();
        logic        rd  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        wr  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3  [4] = '{3'b010, 3'b011, 3'b011, 3'b000};
        logic [31:0] adr [4] = '{32'h102, 32'h104, 32'h108, 32'h10C};
        for (int i = 0; i < 4; i++) begin
            issue(rd[i], wr[i], f3[i], adr[i], 32'h55, 5'd6);
            #1;
            n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flt%0d_stall: got %b want 0", i, stall_o); end
            tick();
            idle_inputs();
            n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL flt%0d_err: got %b want 1", i, err_o); end
            n_cmp++; if (wb_data_o !== adr[i]) begin n_err++; $display("FAIL flt%0d_data: got %h want %h", i, wb_data_o, adr[i]); end
            n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL flt%0d_valid: got %b want 0", i, wb_valid_o); end
            n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL flt%0d_req: got %b want 0", i, dmem_req_o); end
            tick();
            n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL flt%0d_pulse: got %b want 0", i, err_o); end
        end
    endtask

    task automatic test_wait_states();
        issue(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5'd9);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL ws_stall_T: got %b want 1", stall_o); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            // Upstream keeps presenting the same op while stalled; it must be ignored
            if (k == 4) begin
                dmem_ready_i = 1'b1;
                #1;
            end
            n_cmp++; if (dmem_req_o !== 1'b1) begin n_err++; $display("FAIL ws%0d_req: got %b want 1", k, dmem_req_o); end
            n_cmp++; if (dmem_addr_o !== 32'h300) begin n_err++; $display("FAIL ws%0d_addr: got %h want 300", k, dmem_addr_o); end
            n_cmp++; if (dmem_be_o !== 4'b1111) begin n_err++; $display("FAIL ws%0d_be: got %b want 1111", k, dmem_be_o); end
            n_cmp++; if (dmem_wdata_o !== 32'hCAFEF00D) begin n_err++; $display("FAIL ws%0d_wdata: got %h want cafef00d", k, dmem_wdata_o); end
            n_cmp++; if (dmem_we_o !== 1'b1) begin n_err++; $display("FAIL ws%0d_we: got %b want 1", k, dmem_we_o); end
            n_cmp++; if (stall_o !== (k < 4)) begin n_err++; $display("FAIL ws%0d_stall: got %b want %b", k, stall_o, k < 4); end
            n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL ws%0d_valid: got %b want 0", k, wb_valid_o); end
        end
        tick();
        idle_inputs();
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL ws_wb_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL ws_req_drop: got %b want 0", dmem_req_o); end
    endtask

    task automatic test_reset_in_wait();
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12);
        tick();
        idle_inputs();
        n_cmp++; if (dmem_req_o !== 1'b1) begin n_err++; $display("FAIL rw_req_pre: got %b want 1", dmem_req_o); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL rw_req: got %b want 0", dmem_req_o); end
        n_cmp++; if (dmem_addr_o !== 32'h0) begin n_err++; $display("FAIL rw_addr: got %h want 0", dmem_addr_o); end
        n_cmp++; if (dmem_be_o !== 4'h0) begin n_err++; $display("FAIL rw_be: got %b want 0000", dmem_be_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rw_stall: got %b want 0", stall_o); end
        n_cmp++; if (wb_data_o !== 32'h0) begin n_err++; $display("FAIL rw_wb_data: got %h want 0", wb_data_o); end
        rst_n = 1'b1;
        // Late ready arrives in IDLE and must be ignored
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h12345678;
        tick();
        dmem_ready_i = 1'b0;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL rw_late_ready: got %b want 0", wb_valid_o); end
        issue(1'b0, 1'b0, 3'b000, 32'h5, 32'h0, 5'd7);
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b want 0", stall_o); end
        tick();
        idle_inputs();
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'h5) begin n_err++; $display("FAIL add_data: got %h want 5", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd7) begin n_err++; $display("FAIL add_rd: got %0d want 7", wb_rd_o); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b0, 3'b000, 32'h11, 32'h0, 5'd1);
        tick();
        n_cmp++; if (wb_data_o !== 32'h11) begin n_err++; $display("FAIL b2b0_data: got %h want 11", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd1) begin n_err++; $display("FAIL b2b0_rd: got %0d want 1", wb_rd_o); end
        issue(1'b0, 1'b0, 3'b000, 32'h22, 32'h0, 5'd2);
        tick();
        idle_inputs();
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b1_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (wb_data_o !== 32'h22) begin n_err++; $display("FAIL b2b1_data: got %h want 22", wb_data_o); end
        n_cmp++; if (wb_rd_o !== 5'd2) begin n_err++; $display("FAIL b2b1_rd: got %0d want 2", wb_rd_o); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extract();
        test_store();
        test_fault();
        test_wait_states();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
